// File: rtl/game_state_ctrl.sv
// Dino runner game sequencer: start/play/lockout/over FSM, frame-tick score counter,
// high score, speed level and new-game pulse. All state on Clk50; frame_Clk is data.
module game_state_ctrl #(
    parameter int unsigned SCORE_DIV   = 6,
    parameter int unsigned SCORE_MAX   = 99999,
    parameter int unsigned LOCK_FRAMES = 30,
    parameter int unsigned LEVEL_STEP  = 100,
    parameter int unsigned LEVEL_MAX   = 7,
    parameter logic [7:0]  KEY_JUMP    = 8'h2C,
    parameter logic [7:0]  KEY_ALT     = 8'h52
) (
    input  logic        Clk50,
    input  logic        Reset,
    input  logic        frame_Clk,
    input  logic [7:0]  keycode,
    input  logic        Dead,
    output logic [1:0]  Game_State,
    output logic [31:0] score,
    output logic [31:0] high_score,
    output logic [2:0]  speed_level,
    output logic        new_game,
    output logic        frame_tick
);

    typedef enum logic [1:0] {START, PLAY, LOCK, OVER} state_t;

    state_t      state, state_next;
    logic        sync1, sync2, sync3;
    logic        key_hit, key_q, press;
    logic [31:0] div_cnt, lock_cnt, level_cnt;
    logic        enter_play, go_dead, score_step;
    logic [1:0]  gs_next;

    assign key_hit = (keycode == KEY_JUMP) | (keycode == KEY_ALT);
    assign press   = key_hit & ~key_q;

    always_comb begin
        state_next = state;
        enter_play = 1'b0;
        go_dead    = 1'b0;
        case (state)
            START: if (press) begin
                state_next = PLAY;
                enter_play = 1'b1;
            end
            PLAY: if (Dead) begin
                state_next = LOCK;
                go_dead    = 1'b1;
            end
            LOCK: if (frame_tick && lock_cnt == LOCK_FRAMES - 1) state_next = OVER;
            OVER: if (press) begin
                state_next = PLAY;
                enter_play = 1'b1;
            end
            default: state_next = START;
        endcase
        // Dead has priority over a score tick landing in the same cycle
        score_step = (state == PLAY) && !Dead && frame_tick && (div_cnt == SCORE_DIV - 1);
        case (state_next)
            START:   gs_next = 2'b00;
            PLAY:    gs_next = 2'b01;
            default: gs_next = 2'b10;
        endcase
    end

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            state       <= START;
            Game_State  <= 2'b00;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            frame_tick  <= 1'b0;
            key_q       <= 1'b0;
            score       <= '0;
            high_score  <= '0;
            speed_level <= '0;
            new_game    <= 1'b0;
            div_cnt     <= '0;
            lock_cnt    <= '0;
            level_cnt   <= '0;
        end else begin
            state      <= state_next;
            Game_State <= gs_next;
            sync1      <= frame_Clk;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= sync2 & ~sync3;
            key_q      <= key_hit;
            new_game   <= enter_play;

            if (enter_play) begin
                score       <= '0;
                div_cnt     <= '0;
                level_cnt   <= '0;
                speed_level <= '0;
            end else if (state == PLAY && !Dead && frame_tick) begin
                div_cnt <= score_step ? '0 : div_cnt + 32'd1;
                // level tracking freezes once score has saturated
                if (score_step && score < SCORE_MAX) begin
                    score <= score + 32'd1;
                    if (level_cnt + 32'd1 == LEVEL_STEP) begin
                        level_cnt <= '0;
                        if (speed_level < 3'(LEVEL_MAX)) speed_level <= speed_level + 3'd1;
                    end else begin
                        level_cnt <= level_cnt + 32'd1;
                    end
                end
            end

            if (go_dead) begin
                lock_cnt <= '0;
                if (score > high_score) high_score <= score;
            end else if (state == LOCK && frame_tick) begin
                lock_cnt <= lock_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: default instance plus a small-limit instance
// for saturation and speed-level checks.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic        dead = 1'b0;

    logic [1:0]  gs, gs2;
    logic [31:0] score, high_score, score2, high_score2;
    logic [2:0]  level, level2;
    logic        new_game, new_game2, tick, tick2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_ctrl dut (
        .Clk50(clk), .Reset(rst), .frame_Clk(frame_clk), .keycode(keycode), .Dead(dead),
        .Game_State(gs), .score(score), .high_score(high_score), .speed_level(level),
        .new_game(new_game), .frame_tick(tick)
    );

    game_state_ctrl #(.SCORE_MAX(12), .LEVEL_STEP(5)) dut2 (
        .Clk50(clk), .Reset(rst), .frame_Clk(frame_clk), .keycode(keycode), .Dead(dead),
        .Game_State(gs2), .score(score2), .high_score(high_score2), .speed_level(level2),
        .new_game(new_game2), .frame_tick(tick2)
    );

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (4) @(negedge clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gs !== 2'b00) begin errors++; $display("FAIL reset_gs got %b exp 00", gs); end
        checks++; if (score !== 32'd0 || high_score !== 32'd0) begin errors++;
            $display("FAIL reset_scores got %0d/%0d exp 0/0", score, high_score); end
        checks++; if (level !== 3'd0 || new_game !== 1'b0 || tick !== 1'b0) begin errors++;
            $display("FAIL reset_misc got lvl=%0d ng=%b tick=%b exp 0/0/0", level, new_game, tick); end
    endtask

    task automatic test_frame_tick();
        int highs = 0;
        int lat = 0;
        frame_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) frame_clk = 1'b0;
            @(negedge clk);
            if (tick === 1'b1) begin
                highs++;
                if (lat == 0) lat = i;
            end
        end
        checks++; if (highs !== 1) begin errors++; $display("FAIL tick_width got %0d exp 1", highs); end
        checks++; if (lat < 3 || lat > 4) begin errors++; $display("FAIL tick_latency got %0d exp 3..4", lat); end
        checks++; if (gs !== 2'b00) begin errors++; $display("FAIL tick_start_gs got %b exp 00", gs); end
    endtask

    task automatic test_start();
        keycode = 8'h2C;
        @(negedge clk);
        checks++; if (gs !== 2'b01) begin errors++; $display("FAIL start_gs got %b exp 01", gs); end
        checks++; if (new_game !== 1'b1) begin errors++; $display("FAIL start_new_game got %b exp 1", new_game); end
        checks++; if (score !== 32'd0) begin errors++; $display("FAIL start_score got %0d exp 0", score); end
        @(negedge clk);
        checks++; if (new_game !== 1'b0) begin errors++; $display("FAIL new_game_width got %b exp 0", new_game); end
        keycode = 8'h00;
    endtask

    task automatic test_score();
        frames(60);
        checks++; if (score !== 32'd10) begin errors++; $display("FAIL score_60 got %0d exp 10", score); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL level_60 got %0d exp 0", level); end
    endtask

    task automatic test_dead_on_tick();
        bit seen = 1'b0;
        frames(186);
        checks++; if (score !== 32'd41) begin errors++; $display("FAIL score_246 got %0d exp 41", score); end
        frames(5);
        frame_clk = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL dead_tick_wait got none exp tick"); end
        dead = 1'b1;
        @(negedge clk);
        dead = 1'b0;
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL dead_gs got %b exp 10", gs); end
        checks++; if (score !== 32'd41) begin errors++; $display("FAIL dead_score got %0d exp 41", score); end
        checks++; if (high_score !== 32'd41) begin errors++; $display("FAIL dead_high got %0d exp 41", high_score); end
        frame_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lockout();
        frames(10);
        keycode = 8'h2C;
        repeat (3) @(negedge clk);
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL lock_press10 got %b exp 10", gs); end
        keycode = 8'h00;
        frames(19);
        keycode = 8'h52;
        repeat (3) @(negedge clk);
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL lock_press29 got %b exp 10", gs); end
        frames(1);
        repeat (4) @(negedge clk);
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL over_held_key got %b exp 10", gs); end
        keycode = 8'h00;
        @(negedge clk);
        keycode = 8'h52;
        @(negedge clk);
        checks++; if (gs !== 2'b01) begin errors++; $display("FAIL restart_gs got %b exp 01", gs); end
        checks++; if (new_game !== 1'b1) begin errors++; $display("FAIL restart_new_game got %b exp 1", new_game); end
        checks++; if (score !== 32'd0 || high_score !== 32'd41) begin errors++;
            $display("FAIL restart_scores got %0d/%0d exp 0/41", score, high_score); end
        keycode = 8'h00;
    endtask

    task automatic test_async_reset();
        frames(12);
        checks++; if (score !== 32'd2) begin errors++; $display("FAIL pre_reset_score got %0d exp 2", score); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gs !== 2'b00 || score !== 32'd0 || high_score !== 32'd0) begin errors++;
            $display("FAIL async_reset got gs=%b sc=%0d hi=%0d exp 00/0/0", gs, score, high_score); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        keycode = 8'h52;
        @(negedge clk);
        keycode = 8'h00;
        checks++; if (gs2 !== 2'b01) begin errors++; $display("FAIL sat_start got %b exp 01", gs2); end
        frames(24);
        checks++; if (score2 !== 32'd4 || level2 !== 3'd0) begin errors++;
            $display("FAIL sat_4 got %0d/%0d exp 4/0", score2, level2); end
        frames(6);
        checks++; if (score2 !== 32'd5 || level2 !== 3'd1) begin errors++;
            $display("FAIL sat_5 got %0d/%0d exp 5/1", score2, level2); end
        frames(30);
        checks++; if (score2 !== 32'd10 || level2 !== 3'd2) begin errors++;
            $display("FAIL sat_10 got %0d/%0d exp 10/2", score2, level2); end
        frames(30);
        checks++; if (score2 !== 32'd12 || level2 !== 3'd2) begin errors++;
            $display("FAIL sat_hold got %0d/%0d exp 12/2", score2, level2); end
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_start();
        test_score();
        test_dead_on_tick();
        test_lockout();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
